// File: rtl/uart_recv.sv
// -----------------------------------------------------------------------------
// uart_recv -- 8N1 UART receiver, 16x oversampled, majority-voted bits.
//
// The serial line is synchronised, a falling edge in IDLE starts a frame, and
// every bit cell (start, 8 data, stop) is decided by a 2-of-3 vote of the
// samples taken at sample counts 7, 8 and 9 of that cell. A good stop bit
// loads the received byte and pulses out_flag; a low stop bit pulses
// frame_err and keeps the previous byte.
//
// Parameters
//   SYNC_STAGES : number of rxd synchronizer flops (2..3)
//
// Ports
//   sys_clk   in   system clock, 16x baud rate (one clock = one sample)
//   rst       in   asynchronous active-low reset
//   rxd       in   asynchronous serial line, idle high, LSB first
//   out_dat   out  last correctly framed byte, held until the next good frame
//   out_flag  out  one-cycle pulse: out_dat newly valid
//   frame_err out  one-cycle pulse: stop bit sampled low
//   busy      out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_recv #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] out_dat,
  output logic       out_flag,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // 2-of-3 majority of the three mid-cell samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_s;
  logic                   rx_prev_q, rx_prev_d;
  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [1:0]             vote_q, vote_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             out_dat_q, out_dat_d;
  logic                   out_flag_q, out_flag_d;
  logic                   frame_err_q, frame_err_d;
  logic                   sample_bit;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Synchronizer shift chain and previous-sample tracker for edge detection.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rxd};
    rx_prev_d = rx_s;
  end

  // Receiver FSM: next state, sample counter, bit index, voting and outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 4'd1;   // wraps 15 -> 0 straight into the next cell
    bit_idx_d   = bit_idx_q;
    vote_d      = vote_q;
    shift_d     = shift_q;
    out_dat_d   = out_dat_q;
    out_flag_d  = 1'b0;
    frame_err_d = 1'b0;
    // vote_q holds the count-7 and count-8 samples; rx_s is the count-9 one.
    sample_bit  = maj3(vote_q[1], vote_q[0], rx_s);

    case (cnt_q)
      4'd7:    vote_d = {rx_s, vote_q[0]};
      4'd8:    vote_d = {vote_q[1], rx_s};
      default: vote_d = vote_q;
    endcase

    case (state_q)
      IDLE: begin
        cnt_d     = 4'd0;
        bit_idx_d = 3'd0;
        // Requires a high sample before the low one, so a line stuck low
        // (e.g. after a framing error) never restarts a frame.
        if (rx_prev_q && !rx_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if ((cnt_q == 4'd9) && sample_bit) begin
          // Start bit voted high: a glitch, drop it silently.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd15) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end else begin
          state_d = START;
        end
      end

      DATA: begin
        if (cnt_q == 4'd9) begin
          shift_d = {sample_bit, shift_q[7:1]};
        end else begin
          shift_d = shift_q;
        end
        if (cnt_q == 4'd15) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end

      STOP: begin
        // Decide at count 9 and go idle immediately, leaving the second half
        // of the stop cell free for the next start edge to be seen.
        if (cnt_q == 4'd9) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          if (sample_bit) begin
            out_dat_d  = shift_q;
            out_flag_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= {SYNC_STAGES{1'b1}};
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      bit_idx_q   <= 3'd0;
      vote_q      <= 2'b00;
      shift_q     <= 8'h00;
      out_dat_q   <= 8'h00;
      out_flag_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      vote_q      <= vote_d;
      shift_q     <= shift_d;
      out_dat_q   <= out_dat_d;
      out_flag_q  <= out_flag_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_dat   = out_dat_q;
  assign out_flag  = out_flag_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_recv.sv
module tb_uart_recv;

  localparam int SYNC = 2;
  // Pulse appears SYNC edges after rxd changes (synchroniser), then 154+1
  // cycles after the synchronised falling edge.
  localparam int LATENCY = SYNC + 155;

  logic       sys_clk;
  logic       rst;
  logic       rxd;
  logic [7:0] out_dat;
  logic       out_flag;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic       err;
    logic [7:0] dat;
    int         at;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good;

  uart_recv #(.SYNC_STAGES(SYNC)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .rxd      (rxd),
    .out_dat  (out_dat),
    .out_flag (out_flag),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Monitor: every output pulse is matched against the oldest expected frame.
  always @(negedge sys_clk) begin
    if (rst) begin
      if (out_flag && frame_err) begin
        chk("flag_and_err_together", 1, 0);
      end
      if (out_flag || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, out_flag, frame_err}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind_is_err", int'(frame_err), int'(e.err));
          chk("out_dat", int'(out_dat), int'(e.dat));
          chk("pulse_cycle", cyc, e.at);
          chk("busy_at_pulse", int'(busy), 0);
        end
      end
    end
  end

  // Send one frame. inv_cell >= 0 inverts sample 8 of that cell (1..8 are
  // data bits). abort_rst makes the task return in the middle of data bit 4
  // without registering an expectation.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int inv_cell, input int gap, input bit abort_rst);
    logic [9:0] cells;
    exp_t       e;
    cells = {stop_v, b, 1'b0};
    for (int c = 0; c < 10; c++) begin
      for (int s = 0; s < 16; s++) begin
        @(posedge sys_clk);
        #1;
        if (abort_rst && c == 5 && s == 8) return;
        if (c == 0 && s == 0 && !abort_rst) begin
          e.err = ~stop_v;
          e.dat = stop_v ? b : last_good;
          e.at  = cyc + LATENCY;
          if (stop_v) last_good = b;
          exp_q.push_back(e);
        end
        rxd = (c == inv_cell && s == 8) ? ~cells[c] : cells[c];
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge sys_clk);
      #1;
      rxd = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
      rxd = 1'b1;
    end
  endtask

  initial begin
    int g0;
    last_good = 8'h00;
    rst = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("reset_out_dat", int'(out_dat), 0);
    chk("reset_out_flag", int'(out_flag), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_busy", int'(busy), 0);
    @(posedge sys_clk);
    #1;
    rst = 1'b1;
    idle(10);

    // Single clean frame.
    send_frame(8'hA5, 1'b1, -1, 20, 1'b0);

    // Back-to-back frames, stop bit exactly 16 clocks.
    send_frame(8'h00, 1'b1, -1, 0, 1'b0);
    send_frame(8'hFF, 1'b1, -1, 20, 1'b0);

    // Four-clock low glitch on the idle line.
    @(posedge sys_clk);
    #1;
    g0 = cyc;
    rxd = 1'b0;
    repeat (3) begin
      @(posedge sys_clk);
      #1;
    end
    @(posedge sys_clk);
    #1;
    rxd = 1'b1;
    @(negedge sys_clk);
    chk("glitch_busy_high", int'(busy), 1);
    while (cyc < g0 + SYNC + 11) @(negedge sys_clk);
    chk("glitch_busy_low", int'(busy), 0);
    idle(20);

    // Low stop bit, line held low afterwards: no new frame may start.
    send_frame(8'h3C, 1'b0, -1, 0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      @(posedge sys_clk);
      #1;
      rxd = 1'b0;
    end
    @(negedge sys_clk);
    chk("held_low_no_restart_busy", int'(busy), 0);
    idle(20);
    send_frame(8'h5A, 1'b1, -1, 10, 1'b0);

    // Single-sample inversion at sample 8 of data bit 3.
    send_frame(8'h55, 1'b1, 4, 10, 1'b0);

    // Reset during data bit 4, then a clean frame.
    send_frame(8'hC3, 1'b1, -1, 0, 1'b1);
    rst = 1'b0;
    rxd = 1'b1;
    last_good = 8'h00;
    repeat (2) @(negedge sys_clk);
    chk("midreset_out_dat", int'(out_dat), 0);
    chk("midreset_out_flag", int'(out_flag), 0);
    chk("midreset_frame_err", int'(frame_err), 0);
    chk("midreset_busy", int'(busy), 0);
    @(posedge sys_clk);
    #1;
    rst = 1'b1;
    idle(30);
    @(negedge sys_clk);
    chk("after_reset_busy", int'(busy), 0);
    send_frame(8'h81, 1'b1, -1, 10, 1'b0);

    // Randomised traffic: random bytes, gaps, occasional bad stop bits and
    // single-sample inversions that the vote must absorb.
    for (int k = 0; k < 16; k++) begin
      logic [7:0] b;
      logic       bad;
      int         gap;
      int         inv;
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      gap = bad ? $urandom_range(1, 12) : $urandom_range(0, 12);
      inv = $urandom_range(0, 11);
      inv = (inv >= 1 && inv <= 8) ? inv : -1;
      send_frame(b, ~bad, inv, gap, 1'b0);
    end

    idle(200);
    chk("all_frames_seen", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
